// File: rtl/fc_layer_pkg.sv
// Shared definitions for the fully-connected stage: FSM state encoding,
// default geometry and the DRAM layer base addresses used across the LeNet flow.
package fc_layer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_B = 3'd1,
        S_RD_X = 3'd2,
        S_RD_W = 3'd3,
        S_MAC  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam int FC_DATA_WIDTH = 32;
    localparam int FC_ADDR_WIDTH = 18;
    localparam int FC_FRAC_BITS  = 16;
    localparam int FC_N_IN       = 256;
    localparam int FC_N_OUT      = 10;

    localparam int LENET_FC_IN_BASE  = 0;
    localparam int LENET_FC_W_BASE   = 4096;
    localparam int LENET_FC_B_BASE   = 8192;
    localparam int LENET_FC_OUT_BASE = 12288;

endpackage

// File: rtl/fc_mac.sv
// Saturating fixed-point multiply-accumulate for fc_layer.
// Build option FC_RELU_EN clamps negative results to zero.
module fc_mac
    import fc_layer_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int FRAC_BITS  = FC_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         clear,
    input  logic                         load_bias,
    input  logic                         accumulate,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] w,
    output logic        [DATA_WIDTH-1:0] result
);

    localparam int AW = 2 * DATA_WIDTH;

    logic signed [AW-1:0]         acc_r;
    logic signed [AW-1:0]         prod_s;
    logic signed [AW-1:0]         bias_s;
    logic signed [AW:0]           sum_s;
    logic signed [AW-1:0]         sum_sat_s;
    logic signed [AW-1:0]         shr_s;
    logic        [DATA_WIDTH-1:0] res_sat_s;

    // Product, bias alignment and saturating accumulate.
    always_comb begin
        prod_s = AW'(x) * AW'(w);
        bias_s = AW'(bias) <<< FRAC_BITS;
        sum_s  = (AW + 1)'(acc_r) + (AW + 1)'(prod_s);
        if (sum_s[AW] != sum_s[AW-1]) begin
            sum_sat_s = sum_s[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
        end else begin
            sum_sat_s = sum_s[AW-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            acc_r <= {AW{1'b0}};
        end else if (clear) begin
            acc_r <= {AW{1'b0}};
        end else if (load_bias) begin
            acc_r <= bias_s;
        end else if (accumulate) begin
            acc_r <= sum_sat_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Drop the fraction, then clamp into the word range.
    always_comb begin
        shr_s = acc_r >>> FRAC_BITS;
        if ((&shr_s[AW-1:DATA_WIDTH-1]) || !(|shr_s[AW-1:DATA_WIDTH-1])) begin
            res_sat_s = shr_s[DATA_WIDTH-1:0];
        end else if (shr_s[AW-1]) begin
            res_sat_s = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            res_sat_s = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end
`ifdef FC_RELU_EN
        result = res_sat_s[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : res_sat_s;
`else
        result = res_sat_s;
`endif
    end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected LeNet stage: streams bias, inputs and weights from DRAM and
// writes N_OUT fixed-point dot products back (FC_RELU_EN selects ReLU output in fc_mac).
module fc_layer
    import fc_layer_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ADDR_WIDTH = FC_ADDR_WIDTH,
    parameter int FRAC_BITS  = FC_FRAC_BITS,
    parameter int N_IN       = FC_N_IN,
    parameter int N_OUT      = FC_N_OUT,
    parameter int IN_BASE    = LENET_FC_IN_BASE,
    parameter int W_BASE     = LENET_FC_W_BASE,
    parameter int B_BASE     = LENET_FC_B_BASE,
    parameter int OUT_BASE   = LENET_FC_OUT_BASE
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_wr,
    output logic                  dram_en_rd,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] IN_A   = ADDR_WIDTH'(IN_BASE);
    localparam logic [ADDR_WIDTH-1:0] W_A    = ADDR_WIDTH'(W_BASE);
    localparam logic [ADDR_WIDTH-1:0] B_A    = ADDR_WIDTH'(B_BASE);
    localparam logic [ADDR_WIDTH-1:0] OUT_A  = ADDR_WIDTH'(OUT_BASE);
    localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(N_IN - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_O = ADDR_WIDTH'(N_OUT - 1);

    state_t                  state_r, state_nx;
    logic [ADDR_WIDTH-1:0]   i_r, o_r, wptr_r;
    logic [DATA_WIDTH-1:0]   x_r, w_r, result_s;
    logic                    en_rd_r, en_wr_r, done_r;
    logic [DATA_WIDTH-1:0]   data_out_r;
    logic [ADDR_WIDTH-1:0]   addr_in_r, addr_out_r, rd_addr_s;
    logic issue_s, accept_s, abort_s, clear_s, load_bias_s, acc_en_s;
    logic wr_s, inc_i_s, inc_o_s, latch_x_s, latch_w_s;

    // State register.
    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state and datapath controls; a read is issued only when none is pending.
    always_comb begin
        state_nx = state_r;
        issue_s = 1'b0; accept_s = 1'b0; abort_s = 1'b0; clear_s = 1'b0;
        load_bias_s = 1'b0; acc_en_s = 1'b0; wr_s = 1'b0; inc_i_s = 1'b0;
        inc_o_s = 1'b0; latch_x_s = 1'b0; latch_w_s = 1'b0;
        rd_addr_s = {ADDR_WIDTH{1'b0}};
        case (state_r)
            S_IDLE: begin
                clear_s = 1'b1;
                if (enable) state_nx = S_RD_B;
                else        state_nx = S_IDLE;
            end
            S_RD_B, S_RD_X, S_RD_W: begin
                if (state_r == S_RD_B)      rd_addr_s = B_A + o_r;
                else if (state_r == S_RD_X) rd_addr_s = IN_A + i_r;
                else                        rd_addr_s = wptr_r;
                if (!enable) begin
                    abort_s  = 1'b1;
                    state_nx = S_IDLE;
                end else if (!en_rd_r) begin
                    issue_s = 1'b1;
                end else if (dram_valid) begin
                    accept_s = 1'b1;
                    case (state_r)
                        S_RD_B:  begin load_bias_s = 1'b1; state_nx = S_RD_X; end
                        S_RD_X:  begin latch_x_s = 1'b1;   state_nx = S_RD_W; end
                        S_RD_W:  begin latch_w_s = 1'b1;   state_nx = S_MAC;  end
                        default: state_nx = S_IDLE;
                    endcase
                end else begin
                    state_nx = state_r;
                end
            end
            S_MAC: begin
                if (!enable) begin
                    abort_s  = 1'b1;
                    state_nx = S_IDLE;
                end else if (i_r == LAST_I) begin
                    acc_en_s = 1'b1;
                    state_nx = S_WR;
                end else begin
                    acc_en_s = 1'b1;
                    inc_i_s  = 1'b1;
                    state_nx = S_RD_X;
                end
            end
            S_WR: begin
                if (!enable) begin
                    abort_s  = 1'b1;
                    state_nx = S_IDLE;
                end else if (o_r == LAST_O) begin
                    wr_s     = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    wr_s     = 1'b1;
                    inc_o_s  = 1'b1;
                    state_nx = S_RD_B;
                end
            end
            S_DONE: begin
                if (enable) state_nx = S_DONE;
                else        state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Loop counters, weight pointer and operand latches.
    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            i_r <= {ADDR_WIDTH{1'b0}}; o_r <= {ADDR_WIDTH{1'b0}}; wptr_r <= {ADDR_WIDTH{1'b0}};
            x_r <= {DATA_WIDTH{1'b0}}; w_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (clear_s || load_bias_s) i_r <= {ADDR_WIDTH{1'b0}};
            else if (inc_i_s)           i_r <= i_r + 1'b1;
            else                        i_r <= i_r;
            if (clear_s)      o_r <= {ADDR_WIDTH{1'b0}};
            else if (inc_o_s) o_r <= o_r + 1'b1;
            else              o_r <= o_r;
            // Weights are contiguous across outputs, so the pointer never rewinds mid-layer.
            if (clear_s)       wptr_r <= W_A;
            else if (acc_en_s) wptr_r <= wptr_r + 1'b1;
            else               wptr_r <= wptr_r;
            x_r <= latch_x_s ? data_in : x_r;
            w_r <= latch_w_s ? data_in : w_r;
        end
    end

    // Registered DRAM port and done.
    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            en_rd_r <= 1'b0; addr_in_r <= {ADDR_WIDTH{1'b0}};
            en_wr_r <= 1'b0; addr_out_r <= {ADDR_WIDTH{1'b0}};
            data_out_r <= {DATA_WIDTH{1'b0}}; done_r <= 1'b0;
        end else begin
            if (issue_s) begin
                en_rd_r <= 1'b1; addr_in_r <= rd_addr_s;
            end else if (accept_s || abort_s) begin
                en_rd_r <= 1'b0; addr_in_r <= {ADDR_WIDTH{1'b0}};
            end else begin
                en_rd_r <= en_rd_r; addr_in_r <= addr_in_r;
            end
            en_wr_r    <= wr_s;
            data_out_r <= wr_s ? result_s : {DATA_WIDTH{1'b0}};
            addr_out_r <= wr_s ? (OUT_A + o_r) : {ADDR_WIDTH{1'b0}};
            done_r     <= (state_nx == S_DONE);
        end
    end

    fc_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clk        (clk),
        .srstn      (srstn),
        .clear      (clear_s),
        .load_bias  (load_bias_s),
        .accumulate (acc_en_s),
        .bias       (data_in),
        .x          (x_r),
        .w          (w_r),
        .result     (result_s)
    );

    assign dram_en_rd = en_rd_r;
    assign addr_in    = addr_in_r;
    assign dram_en_wr = en_wr_r;
    assign addr_out   = addr_out_r;
    assign data_out   = data_out_r;
    assign done       = done_r;

endmodule

// File: tb/tb_fc_layer.sv
// Directed and randomized bench for fc_layer with a DRAM responder and an
// arithmetic reference model of the layer.
module tb_fc_layer;

    localparam int DW = 32, AW = 18, NI = 2, NO = 2;
    localparam int IN_BASE = 0, W_BASE = 4096, B_BASE = 8192, OUT_BASE = 12288;
    localparam longint LMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam longint LMIN = 64'sh8000_0000_0000_0000;
    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    logic clk = 1'b0;
    logic srstn, enable;
    logic dram_valid = 1'b0;
    logic [DW-1:0] data_in = 32'h0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_in, addr_out;
    logic dram_en_wr, dram_en_rd, done;

    always #5 clk = ~clk;

    fc_layer #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .srstn(srstn), .enable(enable), .dram_valid(dram_valid),
        .data_in(data_in), .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
        .dram_en_wr(dram_en_wr), .dram_en_rd(dram_en_rd), .done(done)
    );

    logic [31:0] mem [int];
    int rd_log[$];
    int wr_a[$];
    logic [31:0] wr_d[$];
    int n_chk = 0, n_fail = 0;
    int n_req = 0, stab_err = 0, hold_err = 0, idle_err = 0;
    int lat_fixed = 1;
    bit lat_rand = 1'b0;
    int wait_cnt = 0, cur_lat = 1;
    logic [AW-1:0] req_addr = 18'h0;

    // DRAM read responder with programmable latency and request-stability checks.
    always @(negedge clk) begin
        if (srstn || !dram_en_rd) begin
            dram_valid = 1'b0; data_in = 32'h0; wait_cnt = 0;
        end else if (dram_valid) begin
            hold_err++; dram_valid = 1'b0; wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) begin
                n_req++; req_addr = addr_in;
                cur_lat = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
            end else if (addr_in !== req_addr) begin
                stab_err++;
            end
            wait_cnt++;
            if (wait_cnt >= cur_lat) begin
                dram_valid = 1'b1;
                data_in = mem.exists(int'(addr_in)) ? mem[int'(addr_in)] : 32'h0;
                rd_log.push_back(int'(addr_in));
            end
        end
    end

    // Write monitor.
    always @(negedge clk) begin
        if (dram_en_wr === 1'b1) begin
            wr_a.push_back(int'(addr_out)); wr_d.push_back(data_out);
        end else if (data_out !== 32'h0 || addr_out !== 18'h0) begin
            idle_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_out(input int o);
        longint acc, p, s, r;
        logic [31:0] b, x, w;
        b = mem[B_BASE + o];
        acc = longint'($signed(b)) * 64'sd65536;
        for (int i = 0; i < NI; i++) begin
            x = mem[IN_BASE + i];
            w = mem[W_BASE + o * NI + i];
            p = longint'($signed(x)) * longint'($signed(w));
            s = acc + p;
            if (acc > 0 && p > 0 && s < 0) s = LMAX;
            else if (acc < 0 && p < 0 && s >= 0) s = LMIN;
            acc = s;
        end
        r = acc >>> 16;
        if (r > MAX32) r = MAX32;
        else if (r < MIN32) r = MIN32;
`ifdef FC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[31:0];
    endfunction

    task automatic load(input logic [31:0] b0, b1, x0, x1, w00, w01, w10, w11);
        mem[B_BASE] = b0; mem[B_BASE + 1] = b1;
        mem[IN_BASE] = x0; mem[IN_BASE + 1] = x1;
        mem[W_BASE] = w00; mem[W_BASE + 1] = w01; mem[W_BASE + 2] = w10; mem[W_BASE + 3] = w11;
    endtask

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 1) == 1) return $urandom;
        else return 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
    endfunction

    task automatic run_and_check(input string tag);
        int r0, w0, q0, s0, h0, i0, c, k;
        r0 = rd_log.size(); w0 = wr_a.size(); q0 = n_req;
        s0 = stab_err; h0 = hold_err; i0 = idle_err;
        @(negedge clk); enable = 1'b1;
        c = 0;
        while (c < 3000 && done !== 1'b1) begin @(negedge clk); c++; end
        chk({tag, " done"}, done, 1);
        @(negedge clk);
        chk({tag, " done_held"}, done, 1);
        chk({tag, " wr_count"}, wr_a.size() - w0, NO);
        for (int o = 0; o < NO; o++) begin
            if (w0 + o < wr_a.size()) begin
                chk({tag, " wr_addr"}, wr_a[w0 + o], OUT_BASE + o);
                chk({tag, " wr_data"}, wr_d[w0 + o], ref_out(o));
            end
        end
        chk({tag, " n_req"}, n_req - q0, NO * (2 * NI + 1));
        chk({tag, " rd_stable"}, stab_err - s0, 0);
        chk({tag, " rd_drop"}, hold_err - h0, 0);
        chk({tag, " wr_idle_zero"}, idle_err - i0, 0);
        k = r0;
        for (int o = 0; o < NO; o++) begin
            if (k < rd_log.size()) chk({tag, " rd_b"}, rd_log[k], B_BASE + o);
            k++;
            for (int i = 0; i < NI; i++) begin
                if (k < rd_log.size()) chk({tag, " rd_x"}, rd_log[k], IN_BASE + i);
                k++;
                if (k < rd_log.size()) chk({tag, " rd_w"}, rd_log[k], W_BASE + o * NI + i);
                k++;
            end
        end
        enable = 1'b0;
        @(negedge clk);
        chk({tag, " done_clear"}, done, 0);
    endtask

    initial begin
        int wb, c;
        logic [31:0] exp3;
        srstn = 1'b1; enable = 1'b0;
        #1;
        chk("reset_outputs", {data_out, addr_in, addr_out, dram_en_wr, dram_en_rd, done}, 0);
        @(negedge clk); @(negedge clk); srstn = 1'b0;

        // 1: basic dot product
        load(32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0003_0000,
             32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_8000);
        wb = wr_a.size();
        run_and_check("t1");
        if (wr_d.size() > wb) chk("t1 const", wr_d[wb], 32'h0005_0000);

        // 2: positive saturation
        load(32'h0, 32'h0, 32'h7FFF_0000, 32'h7FFF_0000,
             32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000);
        wb = wr_a.size();
        run_and_check("t2");
        if (wr_d.size() > wb) chk("t2 const", wr_d[wb], 32'h7FFF_FFFF);

        // 3: negative result (ReLU dependent)
        load(32'hFFFE_0000, 32'h0003_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef FC_RELU_EN
        exp3 = 32'h0;
`else
        exp3 = 32'hFFFE_0000;
`endif
        wb = wr_a.size();
        run_and_check("t3");
        if (wr_d.size() > wb) chk("t3 const", wr_d[wb], exp3);

        // 4: slow DRAM
        load(32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0003_0000,
             32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_8000);
        lat_fixed = 6;
        run_and_check("t4");
        lat_fixed = 1;

        // 5: async reset during MAC of o=0, then a full rerun
        wb = rd_log.size();
        @(negedge clk); enable = 1'b1;
        c = 0;
        while (c < 200 && rd_log.size() < wb + 3) begin @(posedge clk); c++; end
        chk("t5 reach_mac", rd_log.size() >= wb + 3, 1);
        #1 srstn = 1'b1;
        #1 chk("t5 rst_outputs", {data_out, addr_in, addr_out, dram_en_wr, dram_en_rd, done}, 0);
        enable = 1'b0;
        @(negedge clk); srstn = 1'b0;
        run_and_check("t5");

        // 5b: async reset while a read is pending clears the request at once
        lat_fixed = 20;
        @(negedge clk); enable = 1'b1;
        c = 0;
        while (c < 50 && dram_en_rd !== 1'b1) begin @(posedge clk); c++; end
        chk("t5b rd_pending", dram_en_rd, 1);
        #1 srstn = 1'b1;
        #1 chk("t5b rst_rd", {dram_en_rd, addr_in}, 0);
        enable = 1'b0;
        @(negedge clk); srstn = 1'b0;
        lat_fixed = 1;

        // 6: enable dropped in RD_W
        wb = wr_a.size();
        c = rd_log.size();
        @(negedge clk); enable = 1'b1;
        for (int n = 0; n < 200 && rd_log.size() < c + 2; n++) @(posedge clk);
        chk("t6 reach_rdw", rd_log.size() >= c + 2, 1);
        #1 enable = 1'b0;
        @(posedge clk); #1;
        chk("t6 rd_dropped", dram_en_rd, 0);
        repeat (10) @(negedge clk);
        chk("t6 no_write", wr_a.size() - wb, 0);
        chk("t6 no_done", done, 0);

        // Randomized operands with random read latency
        lat_rand = 1'b1;
        for (int t = 0; t < 4; t++) begin
            load(rnd_word(), rnd_word(), rnd_word(), rnd_word(),
                 rnd_word(), rnd_word(), rnd_word(), rnd_word());
            run_and_check($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
